adc_spi_responder: RTL

//  Synthesizable behavioural model of the SPI ADC chip that the ADC receiver controller talks to.

---
 rtl/adc_spi_if.sv | 29 ++
 rtl/adc_spi_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_if.sv
// SPI pin bundle between the ADC receiver controller and the ADC chip model,
// plus the bench-facing sample/config/status signals of the chip model.
interface adc_spi_if #(
    parameter int unsigned DATA_BITS = 12,
    parameter int unsigned CFG_BITS  = 8
);
    logic [DATA_BITS-1:0] sample_data;
    logic                 sck;
    logic                 convst;
    logic                 sdi;
    logic                 sdo;
    logic                 busy;
    logic [CFG_BITS-1:0]  cfg_word;
    logic                 cfg_dv;
    logic                 overrun;
    logic                 abort;

    // Controller/bench side
    modport master (
        output sample_data, sck, convst, sdi,
        input  sdo, busy, cfg_word, cfg_dv, overrun, abort
    );

    // ADC chip side
    modport slave (
        input  sample_data, sck, convst, sdi,
        output sdo, busy, cfg_word, cfg_dv, overrun, abort
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Behavioural SPI ADC chip: oversamples convst/sck/sdi, runs a timed conversion,
// shifts the latched sample out MSB-first on sdo and captures the config word from sdi.
module adc_spi_responder #(
    parameter int unsigned DATA_BITS   = 12,
    parameter int unsigned CFG_BITS    = 8,
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic      i_clk,
    input logic      i_rst_n,
    adc_spi_if.slave bus
);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam int unsigned CCW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic [BCW-1:0] CFG_CNT   = BCW'(CFG_BITS);
    localparam logic [BCW-1:0] DATA_CNT  = BCW'(DATA_BITS);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [CCW-1:0] CONV_LOAD = CCW'(CONV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] convst_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_d;
    logic                   convst_d;

    logic sck_s;
    logic convst_s;
    logic sdi_s;
    logic sck_rise;
    logic sck_fall;
    logic convst_rise;

    logic [DATA_BITS-1:0] tx_sr,    tx_sr_nxt;
    logic [CFG_BITS-1:0]  cfg_sr,   cfg_sr_nxt;
    logic [BCW-1:0]       bit_cnt,  bit_cnt_nxt;
    logic [CCW-1:0]       conv_cnt, conv_cnt_nxt;
    logic                 sdo,      sdo_nxt;
    logic                 busy,     busy_nxt;
    logic [CFG_BITS-1:0]  cfg_word, cfg_word_nxt;
    logic                 dv_pend,  dv_pend_nxt;
    logic                 cfg_dv;
    logic                 overrun,  overrun_nxt;
    logic                 abort,    abort_nxt;
    logic                 start;

    // Synchronisers plus one edge-detect flop per control pin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync    <= '0;
            convst_sync <= '0;
            sdi_sync    <= '0;
            sck_d       <= 1'b0;
            convst_d    <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], bus.convst};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
            sck_d       <= sck_s;
            convst_d    <= convst_s;
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign convst_s    = convst_sync[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign convst_rise = convst_s & ~convst_d;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tx_sr    <= '0;
            cfg_sr   <= '0;
            bit_cnt  <= '0;
            conv_cnt <= '0;
            sdo      <= 1'b0;
            busy     <= 1'b0;
            cfg_word <= '0;
            dv_pend  <= 1'b0;
            cfg_dv   <= 1'b0;
            overrun  <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_sr    <= tx_sr_nxt;
            cfg_sr   <= cfg_sr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            conv_cnt <= conv_cnt_nxt;
            sdo      <= sdo_nxt;
            busy     <= busy_nxt;
            cfg_word <= cfg_word_nxt;
            dv_pend  <= dv_pend_nxt;
            cfg_dv   <= dv_pend;
            overrun  <= overrun_nxt;
            abort    <= abort_nxt;
        end
    end

    // Next-state and next-output logic; a convst rise always outranks an sck edge
    always_comb begin
        state_nxt    = state;
        tx_sr_nxt    = tx_sr;
        cfg_sr_nxt   = cfg_sr;
        bit_cnt_nxt  = bit_cnt;
        conv_cnt_nxt = conv_cnt;
        sdo_nxt      = sdo;
        busy_nxt     = busy;
        cfg_word_nxt = cfg_word;
        dv_pend_nxt  = 1'b0;
        overrun_nxt  = 1'b0;
        abort_nxt    = 1'b0;
        start        = 1'b0;

        unique case (state)
            IDLE: begin
                sdo_nxt = 1'b0;
                start   = convst_rise;
            end

            CONVERT: begin
                overrun_nxt = convst_rise;
                if (conv_cnt == '0) begin
                    busy_nxt    = 1'b0;
                    sdo_nxt     = tx_sr[DATA_BITS-1];
                    bit_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                end else begin
                    conv_cnt_nxt = conv_cnt - CCW'(1);
                end
            end

            SHIFT: begin
                if (convst_rise) begin
                    abort_nxt = 1'b1;
                    start     = 1'b1;
                end else if (sck_rise) begin
                    if (bit_cnt < CFG_CNT) begin
                        cfg_sr_nxt = CFG_BITS'({cfg_sr, sdi_s});
                    end
                    bit_cnt_nxt = bit_cnt + BCW'(1);
                    // Final rise: publish the word including this edge's bit if it was captured
                    if (bit_cnt == LAST_BIT) begin
                        cfg_word_nxt = cfg_sr_nxt;
                        dv_pend_nxt  = 1'b1;
                        sdo_nxt      = 1'b0;
                        state_nxt    = IDLE;
                    end
                end else if (sck_fall && (bit_cnt < DATA_CNT)) begin
                    tx_sr_nxt = {tx_sr[DATA_BITS-2:0], 1'b0};
                    sdo_nxt   = tx_sr[DATA_BITS-2];
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (start) begin
            tx_sr_nxt    = bus.sample_data;
            conv_cnt_nxt = CONV_LOAD;
            busy_nxt     = 1'b1;
            sdo_nxt      = 1'b0;
            cfg_sr_nxt   = '0;
            bit_cnt_nxt  = '0;
            state_nxt    = CONVERT;
        end
    end

    assign bus.sdo      = sdo;
    assign bus.busy     = busy;
    assign bus.cfg_word = cfg_word;
    assign bus.cfg_dv   = cfg_dv;
    assign bus.overrun  = overrun;
    assign bus.abort    = abort;
endmodule
